interface_direcao_ultrassom: RTL and testbench
==============================================

Name: interface_direcao_ultrassom

Overview:
- Upstream stage of the game core. Converts the two HC-SR04 ultrasonic sensors (left and right) into registered direction requests `esq`/`dir` plus a one-cycle `pronto` pulse.
- Each `medir` request runs this sequence:
  - trigger the left sensor, measure its echo width;
  - wait a guard gap (anti-crosstalk);
  - trigger the right sensor, measure its echo width;
  - compare both widths against a proximity threshold and publish the decision.

Parameters:
- T_TRIGGER, 500: trigger pulse width in clock cycles (10 us at 50 MHz).
- T_TIMEOUT, 1500000: maximum cycles from end of trigger to echo fall (30 ms).
- T_GAP, 500000: idle cycles between left and right measurement (10 ms).
- LIMIAR, 43500: echo width in cycles below which a hand is "near" (about 15 cm).
- W_MED, 21: width of measurement counters and outputs.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- medir  in  1  start request; sampled in IDLE only
- echo_esq  in  1  left sensor echo, asynchronous
- echo_dir  in  1  right sensor echo, asynchronous
- trigger_esq  out  1  left sensor trigger
- trigger_dir  out  1  right sensor trigger
- esq  out  1  left-near decision, held until the next decision
- dir  out  1  right-near decision, held until the next decision
- pronto  out  1  one-cycle pulse when esq/dir/medidas are updated
- ocupado  out  1  high in every state except IDLE
- medida_esq  out  W_MED  last left echo width in cycles (0 on timeout)
- medida_dir  out  W_MED  last right echo width in cycles (0 on timeout)
- timeout_esq  out  1  last left measurement timed out
- timeout_dir  out  1  last right measurement timed out
- db_estado  out  4  current FSM state encoding

Behaviour:
- Reset (async): state IDLE. All outputs 0, counters 0. db_estado=0.
- Echo inputs: 2-FF synchronizer each, plus one registered copy for edge detection. Latency is 2 cycles from pin to the synchronized level.
- FSM states and transitions, with db_estado encoding in brackets:
  - IDLE [0]: on medir=1, go to TRIG_E.
  - TRIG_E [1]: trigger_esq=1 for exactly T_TRIGGER cycles, then WAIT_E.
  - WAIT_E [2]: on synced rising edge of echo_esq, go to MED_E.
  - MED_E [3]: width counter increments each cycle while the synced echo is high. On falling edge, latch the width, go to GAP.
  - GAP [4]: T_GAP cycles, then TRIG_D.
  - TRIG_D [5], WAIT_D [6], MED_D [7]: same as the left states, using the right sensor.
  - DECIDE [8]: compute esq/dir, then DONE.
  - DONE [9]: pronto=1 for one cycle, then IDLE.
- Timeout counter:
  - Cleared on entry to WAIT_x; counts through WAIT_x and MED_x.
  - Reaching T_TIMEOUT-1: medida_x=0, timeout_x=1, advance as if the echo fell.
  - A completed measurement sets timeout_x=0.
- Echo already high on entry to WAIT_x: not a rising edge, so it is ignored. The block waits for a fresh rising edge or the timeout.
- Width rule: width counter saturates at 2^W_MED-1. No wrap-around.
- Decision rule, where near_x = !timeout_x && medida_x < LIMIAR:
  - esq = near_esq && !near_dir
  - dir = near_dir && !near_esq
  - Both near, or neither near: esq=dir=0.
  - esq and dir are never 1 simultaneously.
- medida_x, timeout_x, esq and dir update only in DECIDE. They are stable from pronto until the next DECIDE.
- Latency: pronto occurs 2T_TRIGGER + T_GAP + (both echo times) + about 8 sync/FSM cycles after medir.
- medir while busy (any state except IDLE): ignored, not queued.
- medir held high: a new cycle starts on the cycle after DONE.
- Reset mid-operation: immediately back to IDLE.
  - Triggers drop low in the same cycle (async).
  - esq/dir are cleared.
- trigger_esq and trigger_dir are registered outputs. They are never high together.

Decomposition:
- Shared package constants: FSM state encodings (4-bit, values 0..9 as above), default timing constants (T_TRIGGER, T_TIMEOUT, T_GAP, LIMIAR at 50 MHz).
- Sub-module medidor_eco, instantiated twice (one per sensor):
  - Contents: synchronizer, edge detect, width counter with saturation, timeout counter.
  - Controls: start_trig/medindo from the top FSM.
  - Returns: echo_subiu, echo_desceu, largura, estourou.
- The top FSM sequences the two instances and owns the GAP counter and the decision registers.

Test Plan:
- Left near: medir pulse, left echo 20000 cycles, right echo 100000 cycles.
  -> trigger_esq high exactly 500 cycles; medida_esq=20000±2; medida_dir=100000±2; esq=1, dir=0; one pronto pulse.
- Right near: left echo 80000, right echo 30000.
  -> esq=0, dir=1; trigger_dir rises only after 500000 idle cycles following the left echo fall.
- Both near: both echoes 10000.
  -> esq=dir=0, pronto=1. Repeat with both 60000 -> esq=dir=0.
- Timeout: left echo never rises; right echo 20000.
  -> timeout_esq=1, medida_esq=0, dir=1; the left phase lasts exactly T_TIMEOUT cycles after trigger end.
- Echo stuck high before WAIT_E: echo_esq held high from before medir until timeout.
  -> no measurement, timeout_esq=1. Also verify a second medir during MED_E is ignored: exactly one pronto.
- Reset in MED_D: assert reset mid-measurement.
  -> same cycle: state 0, triggers 0, esq=dir=0, pronto=0. A subsequent medir completes a normal cycle.

Source files
------------

// File: rtl/interface_direcao_ultrassom_pkg.sv
// Shared constants for the dual HC-SR04 direction interface: FSM state
// encodings (also exported on db_estado) and default 50 MHz timing.
package interface_direcao_ultrassom_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_TRIG_E = 4'd1;
  localparam logic [3:0] ST_WAIT_E = 4'd2;
  localparam logic [3:0] ST_MED_E  = 4'd3;
  localparam logic [3:0] ST_GAP    = 4'd4;
  localparam logic [3:0] ST_TRIG_D = 4'd5;
  localparam logic [3:0] ST_WAIT_D = 4'd6;
  localparam logic [3:0] ST_MED_D  = 4'd7;
  localparam logic [3:0] ST_DECIDE = 4'd8;
  localparam logic [3:0] ST_DONE   = 4'd9;

  localparam int T_TRIGGER_DEF = 500;
  localparam int T_TIMEOUT_DEF = 1500000;
  localparam int T_GAP_DEF     = 500000;
  localparam int LIMIAR_DEF    = 43500;
  localparam int W_MED_DEF     = 21;

endpackage

// File: rtl/interface_direcao_ultrassom_medidor_eco.sv
// One ultrasonic echo channel: 2-FF synchronizer, edge detection,
// saturating width counter and timeout counter, sequenced by the top FSM.
module medidor_eco #(
  parameter int T_TIMEOUT = 1500000,
  parameter int W_MED     = 21
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             echo,
  input  logic             start_trig,
  input  logic             medindo,
  input  logic             contando,
  output logic             echo_subiu,
  output logic             echo_desceu,
  output logic [W_MED-1:0] largura,
  output logic             estourou
);

  localparam int W_TMO = $clog2(T_TIMEOUT) + 1;
  localparam logic [W_TMO-1:0] TMO_FIM   = W_TMO'(T_TIMEOUT - 1);
  localparam logic [W_MED-1:0] LARG_MAX  = {W_MED{1'b1}};
  localparam logic [W_MED-1:0] LARG_UM   = {{(W_MED-1){1'b0}}, 1'b1};
  localparam logic [W_TMO-1:0] TMO_UM    = {{(W_TMO-1){1'b0}}, 1'b1};

  logic             sync1_r;
  logic             sync2_r;
  logic             eco_ant_r;
  logic [W_TMO-1:0] tmo_cnt_r;
  logic [W_MED-1:0] largura_r;
  logic             conta_largura_s;

  // synchronize the asynchronous echo pin and keep one cycle of history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      eco_ant_r <= 1'b0;
    end else begin
      sync1_r   <= echo;
      sync2_r   <= sync1_r;
      eco_ant_r <= sync2_r;
    end
  end

  assign echo_subiu  = sync2_r & ~eco_ant_r;
  assign echo_desceu = ~sync2_r & eco_ant_r;

  // the rising-edge cycle itself is counted so the width matches the pulse length
  assign conta_largura_s = sync2_r & (contando | (medindo & echo_subiu));

  // width and timeout counters, cleared while the trigger pulse is out
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_r <= {W_TMO{1'b0}};
      largura_r <= {W_MED{1'b0}};
    end else if (start_trig) begin
      tmo_cnt_r <= {W_TMO{1'b0}};
      largura_r <= {W_MED{1'b0}};
    end else begin
      if (medindo) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_UM;
      end
      if (conta_largura_s && (largura_r != LARG_MAX)) begin
        largura_r <= largura_r + LARG_UM;
      end
    end
  end

  assign largura  = largura_r;
  assign estourou = medindo & (tmo_cnt_r == TMO_FIM);

endmodule

// File: rtl/interface_direcao_ultrassom.sv
// Sequences the left and right ultrasonic measurements and publishes a
// registered left/right proximity decision with a one-cycle pronto pulse.
module interface_direcao_ultrassom
  import interface_direcao_ultrassom_pkg::*;
#(
  parameter int T_TRIGGER = T_TRIGGER_DEF,
  parameter int T_TIMEOUT = T_TIMEOUT_DEF,
  parameter int T_GAP     = T_GAP_DEF,
  parameter int LIMIAR    = LIMIAR_DEF,
  parameter int W_MED     = W_MED_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             medir,
  input  logic             echo_esq,
  input  logic             echo_dir,
  output logic             trigger_esq,
  output logic             trigger_dir,
  output logic             esq,
  output logic             dir,
  output logic             pronto,
  output logic             ocupado,
  output logic [W_MED-1:0] medida_esq,
  output logic [W_MED-1:0] medida_dir,
  output logic             timeout_esq,
  output logic             timeout_dir,
  output logic [3:0]       db_estado
);

  localparam int CNT_MAX = (T_GAP > T_TRIGGER) ? T_GAP : T_TRIGGER;
  localparam int W_CNT   = $clog2(CNT_MAX) + 1;
  localparam logic [W_CNT-1:0] CNT_TRIG_FIM = W_CNT'(T_TRIGGER - 1);
  localparam logic [W_CNT-1:0] CNT_GAP_FIM  = W_CNT'(T_GAP - 1);
  localparam logic [W_CNT-1:0] CNT_UM       = {{(W_CNT-1){1'b0}}, 1'b1};
  localparam logic [W_MED-1:0] LIMIAR_W     = W_MED'(LIMIAR);

  logic [3:0]       state_r;
  logic [3:0]       prox_s;
  logic [W_CNT-1:0] cnt_r;
  logic             tmo_e_r, tmo_d_r;
  logic             trigger_esq_r, trigger_dir_r, pronto_r, ocupado_r;
  logic             esq_r, dir_r, timeout_esq_r, timeout_dir_r;
  logic [W_MED-1:0] medida_esq_r, medida_dir_r;
  logic             subiu_e_s, desceu_e_s, est_e_s;
  logic             subiu_d_s, desceu_d_s, est_d_s;
  logic [W_MED-1:0] larg_e_s, larg_d_s;
  logic             perto_e_s, perto_d_s;

  medidor_eco #(.T_TIMEOUT(T_TIMEOUT), .W_MED(W_MED)) u_eco_esq (
    .clock       (clock),
    .reset       (reset),
    .echo        (echo_esq),
    .start_trig  (state_r == ST_TRIG_E),
    .medindo     ((state_r == ST_WAIT_E) || (state_r == ST_MED_E)),
    .contando    (state_r == ST_MED_E),
    .echo_subiu  (subiu_e_s),
    .echo_desceu (desceu_e_s),
    .largura     (larg_e_s),
    .estourou    (est_e_s)
  );

  medidor_eco #(.T_TIMEOUT(T_TIMEOUT), .W_MED(W_MED)) u_eco_dir (
    .clock       (clock),
    .reset       (reset),
    .echo        (echo_dir),
    .start_trig  (state_r == ST_TRIG_D),
    .medindo     ((state_r == ST_WAIT_D) || (state_r == ST_MED_D)),
    .contando    (state_r == ST_MED_D),
    .echo_subiu  (subiu_d_s),
    .echo_desceu (desceu_d_s),
    .largura     (larg_d_s),
    .estourou    (est_d_s)
  );

  // next-state logic; a falling edge wins over a simultaneous timeout in MED
  always_comb begin
    prox_s = state_r;
    case (state_r)
      ST_IDLE:   if (medir) prox_s = ST_TRIG_E; else prox_s = ST_IDLE;
      ST_TRIG_E: if (cnt_r == CNT_TRIG_FIM) prox_s = ST_WAIT_E; else prox_s = ST_TRIG_E;
      ST_WAIT_E: if (est_e_s) prox_s = ST_GAP;
                 else if (subiu_e_s) prox_s = ST_MED_E;
                 else prox_s = ST_WAIT_E;
      ST_MED_E:  if (desceu_e_s || est_e_s) prox_s = ST_GAP; else prox_s = ST_MED_E;
      ST_GAP:    if (cnt_r == CNT_GAP_FIM) prox_s = ST_TRIG_D; else prox_s = ST_GAP;
      ST_TRIG_D: if (cnt_r == CNT_TRIG_FIM) prox_s = ST_WAIT_D; else prox_s = ST_TRIG_D;
      ST_WAIT_D: if (est_d_s) prox_s = ST_DECIDE;
                 else if (subiu_d_s) prox_s = ST_MED_D;
                 else prox_s = ST_WAIT_D;
      ST_MED_D:  if (desceu_d_s || est_d_s) prox_s = ST_DECIDE; else prox_s = ST_MED_D;
      ST_DECIDE: prox_s = ST_DONE;
      ST_DONE:   prox_s = ST_IDLE;
      default:   prox_s = ST_IDLE;
    endcase
  end

  assign perto_e_s = ~tmo_e_r & (larg_e_s < LIMIAR_W);
  assign perto_d_s = ~tmo_d_r & (larg_d_s < LIMIAR_W);

  // state, phase counter and registered strobes derived from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {W_CNT{1'b0}};
      trigger_esq_r <= 1'b0;
      trigger_dir_r <= 1'b0;
      pronto_r      <= 1'b0;
      ocupado_r     <= 1'b0;
    end else begin
      state_r       <= prox_s;
      trigger_esq_r <= (prox_s == ST_TRIG_E);
      trigger_dir_r <= (prox_s == ST_TRIG_D);
      pronto_r      <= (prox_s == ST_DONE);
      ocupado_r     <= (prox_s != ST_IDLE);
      if (prox_s != state_r) begin
        cnt_r <= {W_CNT{1'b0}};
      end else if ((state_r == ST_TRIG_E) || (state_r == ST_TRIG_D) || (state_r == ST_GAP)) begin
        cnt_r <= cnt_r + CNT_UM;
      end
    end
  end

  // remember how each side ended; published only in DECIDE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_e_r <= 1'b0;
      tmo_d_r <= 1'b0;
    end else begin
      if (state_r == ST_TRIG_E) begin
        tmo_e_r <= 1'b0;
      end else if (est_e_s && !((state_r == ST_MED_E) && desceu_e_s)) begin
        tmo_e_r <= 1'b1;
      end
      if (state_r == ST_TRIG_D) begin
        tmo_d_r <= 1'b0;
      end else if (est_d_s && !((state_r == ST_MED_D) && desceu_d_s)) begin
        tmo_d_r <= 1'b1;
      end
    end
  end

  // decision registers, held from pronto until the next DECIDE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      esq_r         <= 1'b0;
      dir_r         <= 1'b0;
      timeout_esq_r <= 1'b0;
      timeout_dir_r <= 1'b0;
      medida_esq_r  <= {W_MED{1'b0}};
      medida_dir_r  <= {W_MED{1'b0}};
    end else if (state_r == ST_DECIDE) begin
      esq_r         <= perto_e_s & ~perto_d_s;
      dir_r         <= perto_d_s & ~perto_e_s;
      timeout_esq_r <= tmo_e_r;
      timeout_dir_r <= tmo_d_r;
      medida_esq_r  <= tmo_e_r ? {W_MED{1'b0}} : larg_e_s;
      medida_dir_r  <= tmo_d_r ? {W_MED{1'b0}} : larg_d_s;
    end
  end

  assign trigger_esq = trigger_esq_r;
  assign trigger_dir = trigger_dir_r;
  assign pronto      = pronto_r;
  assign ocupado     = ocupado_r;
  assign esq         = esq_r;
  assign dir         = dir_r;
  assign timeout_esq = timeout_esq_r;
  assign timeout_dir = timeout_dir_r;
  assign medida_esq  = medida_esq_r;
  assign medida_dir  = medida_dir_r;
  assign db_estado   = state_r;

endmodule

// File: tb/tb_interface_direcao_ultrassom.sv
// Directed and randomized bench for interface_direcao_ultrassom with scaled
// timing; expected decisions come from the echo widths the bench generates.
module tb_interface_direcao_ultrassom;

  localparam int T_TRIGGER = 10;
  localparam int T_TIMEOUT = 600;
  localparam int T_GAP     = 40;
  localparam int LIMIAR    = 100;
  localparam int W_MED     = 9;
  localparam int LARG_MAX  = (1 << W_MED) - 1;

  logic             clock = 1'b0;
  logic             reset, medir, echo_esq, echo_dir;
  logic             trigger_esq, trigger_dir, esq, dir, pronto, ocupado;
  logic             timeout_esq, timeout_dir;
  logic [W_MED-1:0] medida_esq, medida_dir;
  logic [3:0]       db_estado;

  int total = 0;
  int bad = 0;
  int pronto_cnt = 0;
  int fase_e = 0;
  bit trig_both = 1'b0;
  bit dec_both = 1'b0;

  interface_direcao_ultrassom #(
    .T_TRIGGER(T_TRIGGER), .T_TIMEOUT(T_TIMEOUT), .T_GAP(T_GAP),
    .LIMIAR(LIMIAR), .W_MED(W_MED)
  ) dut (
    .clock(clock), .reset(reset), .medir(medir),
    .echo_esq(echo_esq), .echo_dir(echo_dir),
    .trigger_esq(trigger_esq), .trigger_dir(trigger_dir),
    .esq(esq), .dir(dir), .pronto(pronto), .ocupado(ocupado),
    .medida_esq(medida_esq), .medida_dir(medida_dir),
    .timeout_esq(timeout_esq), .timeout_dir(timeout_dir),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // background monitors sampled on the inactive edge
  always @(negedge clock) begin
    if (pronto) pronto_cnt <= pronto_cnt + 1;
    if (trigger_esq && trigger_dir) trig_both <= 1'b1;
    if (esq && dir) dec_both <= 1'b1;
    if (db_estado == 4'd1) fase_e <= 0;
    else if (db_estado == 4'd2 || db_estado == 4'd3) fase_e <= fase_e + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // one full medir transaction; we/wd < 0 means that echo never rises
  task automatic run_case(input string nm, input int de, input int we, input int dd,
                          input int wd, input bit stuck, input bit extra);
    int n, p0, me, md;
    bit te, td, ne, nd;
    te = stuck || (we < 0);
    td = (wd < 0);
    me = te ? 0 : ((we > LARG_MAX) ? LARG_MAX : we);
    md = td ? 0 : ((wd > LARG_MAX) ? LARG_MAX : wd);
    ne = !te && (me < LIMIAR);
    nd = !td && (md < LIMIAR);
    p0 = pronto_cnt;
    if (stuck) echo_esq = 1'b1;
    @(negedge clock); medir = 1'b1;
    @(negedge clock); medir = 1'b0;
    n = 0;
    while (trigger_esq && n < 4*T_TRIGGER) begin n++; @(negedge clock); end
    chk({nm, "/trig_esq_width"}, n, T_TRIGGER);
    if (!te) begin
      repeat (de) @(negedge clock);
      echo_esq = 1'b1;
      if (extra) begin
        repeat (5) @(negedge clock);
        chk({nm, "/state_med_e"}, db_estado, 3);
        medir = 1'b1;
        @(negedge clock); medir = 1'b0;
        repeat (we - 6) @(negedge clock);
      end else begin
        repeat (we) @(negedge clock);
      end
      echo_esq = 1'b0;
    end
    n = 0;
    while (!trigger_dir && n < T_TIMEOUT + T_GAP + 100) begin n++; @(negedge clock); end
    chk({nm, "/trig_dir_seen"}, trigger_dir, 1);
    if (!te) chk_rng({nm, "/gap_cycles"}, n, T_GAP, T_GAP + 8);
    echo_esq = 1'b0;
    n = 0;
    while (trigger_dir && n < 4*T_TRIGGER) begin n++; @(negedge clock); end
    chk({nm, "/trig_dir_width"}, n, T_TRIGGER);
    if (!td) begin
      repeat (dd) @(negedge clock);
      echo_dir = 1'b1;
      repeat (wd) @(negedge clock);
      echo_dir = 1'b0;
    end
    n = 0;
    while (!pronto && n < T_TIMEOUT + 100) begin n++; @(negedge clock); end
    chk({nm, "/pronto"}, pronto, 1);
    chk({nm, "/estado_done"}, db_estado, 9);
    chk({nm, "/ocupado"}, ocupado, 1);
    chk({nm, "/esq"}, esq, ne && !nd);
    chk({nm, "/dir"}, dir, nd && !ne);
    chk({nm, "/timeout_esq"}, timeout_esq, te);
    chk({nm, "/timeout_dir"}, timeout_dir, td);
    if (te) chk({nm, "/medida_esq"}, medida_esq, 0);
    else chk_rng({nm, "/medida_esq"}, int'(medida_esq), me - 2, me + 2);
    if (td) chk({nm, "/medida_dir"}, medida_dir, 0);
    else chk_rng({nm, "/medida_dir"}, int'(medida_dir), md - 2, md + 2);
    @(negedge clock);
    chk({nm, "/pronto_one_cycle"}, pronto, 0);
    @(negedge clock);
    chk({nm, "/pronto_count"}, pronto_cnt - p0, 1);
  endtask

  initial begin
    int n, we, wd;
    reset = 1'b1; medir = 1'b0; echo_esq = 1'b0; echo_dir = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset/estado", db_estado, 0);
    chk("reset/triggers", {trigger_esq, trigger_dir}, 0);
    chk("reset/decisao", {esq, dir, pronto, ocupado}, 0);
    chk("reset/medidas", {medida_esq, medida_dir, timeout_esq, timeout_dir}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_case("esq_perto",   3,  40, 3, 230, 1'b0, 1'b0);
    run_case("dir_perto",   3, 180, 3,  70, 1'b0, 1'b0);
    run_case("ambos_perto", 3,  25, 3,  25, 1'b0, 1'b0);
    run_case("ambos_longe", 3, 140, 3, 140, 1'b0, 1'b0);
    run_case("saturacao",   2, 550, 3, 300, 1'b0, 1'b0);
    run_case("eco_preso",   3,   0, 3, 250, 1'b1, 1'b0);
    chk("eco_preso/fase_esq", fase_e, T_TIMEOUT);
    run_case("medir_extra", 3,  60, 3, 300, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      we = int'($urandom_range(5, 300));
      while (we >= 97 && we <= 103) we = int'($urandom_range(5, 300));
      wd = int'($urandom_range(5, 300));
      while (wd >= 97 && wd <= 103) wd = int'($urandom_range(5, 300));
      run_case($sformatf("rand%0d", i), int'($urandom_range(1, 20)), we,
               int'($urandom_range(1, 20)), wd, 1'b0, 1'b0);
    end

    run_case("timeout_esq", 3, -1, 3, 45, 1'b0, 1'b0);
    chk("timeout_esq/fase_esq", fase_e, T_TIMEOUT);

    // reset while the right echo is being measured
    @(negedge clock); medir = 1'b1;
    @(negedge clock); medir = 1'b0;
    n = 0;
    while (trigger_esq && n < 4*T_TRIGGER) begin n++; @(negedge clock); end
    repeat (3) @(negedge clock);
    echo_esq = 1'b1;
    repeat (30) @(negedge clock);
    echo_esq = 1'b0;
    n = 0;
    while (!trigger_dir && n < T_TIMEOUT + T_GAP + 100) begin n++; @(negedge clock); end
    n = 0;
    while (trigger_dir && n < 4*T_TRIGGER) begin n++; @(negedge clock); end
    repeat (3) @(negedge clock);
    echo_dir = 1'b1;
    repeat (20) @(negedge clock);
    chk("rst_mid/estado_antes", db_estado, 7);
    chk("rst_mid/dir_antes", dir, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid/estado", db_estado, 0);
    chk("rst_mid/triggers", {trigger_esq, trigger_dir}, 0);
    chk("rst_mid/esq_dir", {esq, dir}, 0);
    chk("rst_mid/pronto", pronto, 0);
    chk("rst_mid/ocupado", ocupado, 0);
    echo_dir = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    run_case("pos_reset", 3, 30, 3, 150, 1'b0, 1'b0);

    chk("triggers_nunca_juntos", trig_both, 0);
    chk("esq_dir_nunca_juntos", dec_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
